instr_fetch_requester: RTL and testbench

Initiator side of the instruction-memory req/gnt/rvalid interface: issues sequential word fetches to `instruction_memory` and holds at most one transaction in flight. Returned words go into a small prefetch FIFO that the core decode stage drains. A branch redirect flushes the FIFO, discards any in-flight response and restarts fetching at the new address. Sits between `instruction_memory` and the core front end.

---
 rtl/instr_fetch_requester.sv | 171 +++++++++++++++++
 tb/tb_instr_fetch_requester.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_requester.sv
// instr_fetch_requester
//   Initiator side of the instruction-memory req/gnt/rvalid interface. It
//   issues sequential word fetches and keeps at most one transaction in
//   flight. Returned words land in a small prefetch FIFO that the decode stage
//   drains. A branch flushes the FIFO, drops any in-flight response and
//   restarts fetching at the target.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     When defined, a watchdog limits each wait state to TIMEOUT_CYCLES.
//     On expiry it raises a sticky err_o and stops fetching.
//     When undefined, err_o is tied to 0 and waits are unbounded.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   branch_i, branch_addr_i      one-cycle redirect and its target
//   instr_req_o, instr_addr_o    memory request and word-aligned byte address
//   instr_gnt_i                  grant from memory
//   instr_rvalid_i               response valid from memory
//   instr_rdata_i                response data from memory
//   fetch_valid_o                FIFO head is valid
//   fetch_rdata_o, fetch_addr_o  FIFO head word and its byte address
//   fetch_ready_i                consumer pop strobe
//   busy_o                       transaction in flight
//   err_o                        sticky watchdog error
module instr_fetch_requester #(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    FIFO_DEPTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR      = '0,
  parameter int                    TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  output logic                  fetch_valid_o,
  output logic [DATA_WIDTH-1:0] fetch_rdata_o,
  output logic [ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic                  fetch_ready_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  state_t                                state, state_nxt;
  logic [ADDR_WIDTH-1:0]                 pc, pend_addr;
  logic                                  discard;
  logic                                  err, tmo;
  logic                                  push, pop, grant;
  logic [PW-1:0]                         rd_ptr, wr_ptr;
  logic [CW-1:0]                         count;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_data;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] fifo_addr;
  logic                                  unused_addr_lsb;

  // Target byte-offset bits are discarded; fetches are always word aligned.
  assign unused_addr_lsb = ^branch_addr_i[1:0];

  // A watchdog expiry takes priority over a same-cycle grant.
  assign grant = (state == WAIT_GNT) && instr_gnt_i && !tmo;

  // Launch only from IDLE, so the FIFO check covers the single in-flight word.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE:
        if (!err && (count < CW'(FIFO_DEPTH))) state_nxt = WAIT_GNT;
      WAIT_GNT:
        if (tmo)              state_nxt = IDLE;
        else if (instr_gnt_i) state_nxt = WAIT_RVALID;
      WAIT_RVALID:
        if (tmo) state_nxt = IDLE;
        else if (instr_rvalid_i) begin
          state_nxt = IDLE;
          // A branch in the same cycle makes this word stale as well.
          push      = !discard && !branch_i;
        end
      default: state_nxt = IDLE;
    endcase
  end

  // A branch voids any pop in the same cycle because the FIFO is flushed.
  assign pop = fetch_valid_o && fetch_ready_i && !branch_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= BOOT_ADDR;
      pend_addr <= '0;
      discard   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fifo_data <= '0;
      fifo_addr <= '0;
    end else begin
      state <= state_nxt;

      if (branch_i)   pc <= {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
      else if (grant) pc <= pc + ADDR_WIDTH'(4);

      if (grant) pend_addr <= pc;

      // Response is consumed (or abandoned) on leaving WAIT_RVALID, so the flag
      // clears there. Otherwise a branch after the grant marks it stale.
      if (state == WAIT_RVALID && (instr_rvalid_i || tmo))
        discard <= 1'b0;
      else if (branch_i && (grant || state == WAIT_RVALID))
        discard <= 1'b1;

      if (push) begin
        fifo_data[wr_ptr] <= instr_rdata_i;
        fifo_addr[wr_ptr] <= pend_addr;
        wr_ptr            <= wr_ptr + PW'(1);
      end

      if (branch_i) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // Counts cycles spent in the current wait state. It restarts on every
  // state change.
  assign tmo = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_nxt != state)  tmo_cnt <= '0;
      else if (state != IDLE)  tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  assign instr_req_o   = (state == WAIT_GNT);
  assign instr_addr_o  = pc;
  assign fetch_valid_o = (count != '0);
  assign fetch_rdata_o = fifo_data[rd_ptr];
  assign fetch_addr_o  = fifo_addr[rd_ptr];
  assign busy_o        = (state != IDLE);
  assign err_o         = err;

endmodule

// File: tb/tb_instr_fetch_requester.sv
// Directed bench for instr_fetch_requester.
// A behavioural memory grants one cycle after it sees a request. It returns
// data rv_dly cycles after the grant and holds rvalid for rv_hold cycles.
module tb_instr_fetch_requester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_i = 1'b0;
  logic [7:0]  branch_addr_i = '0;
  logic        instr_req_o;
  logic [7:0]  instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        fetch_valid_o;
  logic [31:0] fetch_rdata_o;
  logic [7:0]  fetch_addr_o;
  logic        fetch_ready_i = 1'b0;
  logic        busy_o;
  logic        err_o;

  int nchk = 0;
  int nerr = 0;

  instr_fetch_requester #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(4),
    .BOOT_ADDR(8'h00), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i),
    .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o),
    .fetch_addr_o(fetch_addr_o), .fetch_ready_i(fetch_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [31:0] mem [64];
  logic [7:0]  gq [$];
  logic [7:0]  paddr = '0;
  logic        gnt_en = 1'b1;
  int          rv_dly = 1;
  int          rv_hold = 1;
  int          gwait = 0;
  int          rcnt = 0;
  int          rhold = 0;

  always @(negedge clk) begin
    if (rhold > 0) rhold--;
    if (instr_gnt_i) rcnt = rv_dly;
    instr_gnt_i = 1'b0;
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        rhold = rv_hold;
        instr_rdata_i = mem[paddr[7:2]];
      end
    end
    instr_rvalid_i = (rhold > 0);
    if (instr_req_o && gnt_en) begin
      if (gwait >= 1) begin
        instr_gnt_i = 1'b1;
        paddr = instr_addr_o;
        gq.push_back(instr_addr_o);
        gwait = 0;
      end else gwait++;
    end else gwait = 0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    while (!fetch_valid_o && n < 100) begin tick(); n++; end
    chk({tag, "_vld"}, 64'(fetch_valid_o), 64'd1);
    chk({tag, "_addr"}, 64'(fetch_addr_o), 64'(a));
    chk({tag, "_data"}, 64'(fetch_rdata_o), 64'(d));
    fetch_ready_i = 1'b1;
    tick();
    fetch_ready_i = 1'b0;
  endtask

  task automatic do_branch(input logic [7:0] a);
    branch_addr_i = a;
    branch_i = 1'b1;
    tick();
    branch_i = 1'b0;
  endtask

  // Waits for a request to a given address, then for its grant, so the DUT
  // sits in WAIT_RVALID on return.
  task automatic wait_granted(input string tag, input logic [7:0] a);
    int n = 0;
    while (!(instr_req_o && instr_addr_o == a) && n < 100) begin tick(); n++; end
    chk({tag, "_req"}, 64'(instr_req_o && instr_addr_o == a), 64'd1);
    n = 0;
    while (instr_req_o && n < 100) begin tick(); n++; end
    chk({tag, "_gnt"}, 64'(instr_req_o), 64'd0);
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 4);
    mem[0]    = 32'h00D0_0113;
    mem[1]    = 32'h0090_0093;
    mem[8'h20] = 32'hF81F_F06F;

    // Reset state
    repeat (3) tick();
    chk("rst_req",   64'(instr_req_o),   64'd0);
    chk("rst_addr",  64'(instr_addr_o),  64'h00);
    chk("rst_vld",   64'(fetch_valid_o), 64'd0);
    chk("rst_rdata", 64'(fetch_rdata_o), 64'd0);
    chk("rst_faddr", 64'(fetch_addr_o),  64'd0);
    chk("rst_busy",  64'(busy_o),        64'd0);
    chk("rst_err",   64'(err_o),         64'd0);
    rst = 1'b0;
    tick();
    chk("first_req", 64'(instr_req_o), 64'd1);
    chk("first_addr", 64'(instr_addr_o), 64'h00);

    // Fill and stall: four words, then no further requests
    repeat (40) tick();
    chk("fill_ngnt", 64'(gq.size()), 64'd4);
    chk("fill_req",  64'(instr_req_o), 64'd0);
    pop_check("w0", 8'h00, 32'h00D0_0113);
    repeat (20) tick();
    chk("refill_ngnt", 64'(gq.size()), 64'd5);
    chk("refill_addr", 64'((gq.size() > 4) ? gq[4] : 8'hEE), 64'h10);
    chk("refill_req",  64'(instr_req_o), 64'd0);
    pop_check("w1", 8'h04, 32'h0090_0093);
    pop_check("w2", 8'h08, 32'hC0DE_0008);
    pop_check("w3", 8'h0C, 32'hC0DE_000C);
    pop_check("w4", 8'h10, 32'hC0DE_0010);

    // Branch while waiting on rvalid for 0x08; low target bits are ignored
    rv_dly = 4;
    do_branch(8'h09);
    chk("flush_vld", 64'(fetch_valid_o), 64'd0);
    wait_granted("br08", 8'h08);
    n0 = gq.size();
    do_branch(8'h80);
    chk("brrv_vld", 64'(fetch_valid_o), 64'd0);
    pop_check("br80", 8'h80, 32'hF81F_F06F);
    chk("brrv_next", 64'((gq.size() > n0) ? gq[n0] : 8'hEE), 64'h80);
    pop_check("br84", 8'h84, 32'hC0DE_0084);

    // Address wrap
    rv_dly = 1;
    do_branch(8'hFC);
    pop_check("wrapFC", 8'hFC, 32'hC0DE_00FC);
    pop_check("wrap00", 8'h00, 32'h00D0_0113);
    pop_check("wrap04", 8'h04, 32'h0090_0093);

    // Branch in the same cycle as rvalid drops that word
    do_branch(8'h20);
    wait_granted("co20", 8'h20);
    do_branch(8'h40);
    pop_check("co40", 8'h40, 32'hC0DE_0040);
    pop_check("co44", 8'h44, 32'hC0DE_0044);

    // Level-held rvalid: exactly one word per transaction
    rv_hold = 3;
    do_branch(8'h30);
    for (int i = 0; i < 6; i++)
      pop_check($sformatf("lvl%0d", i), 8'(8'h30 + 4 * i), 32'hC0DE_0030 + 32'(4 * i));
    rv_hold = 1;
    repeat (30) tick();

`ifdef FETCH_TIMEOUT_EN
    // Never grant: watchdog fires after 8 WAIT_GNT cycles
    begin
      int nreq = 0;
      gnt_en = 1'b0;
      do_branch(8'h00);
      for (int i = 0; i < 40 && !err_o; i++) begin
        tick();
        if (!err_o && instr_req_o) nreq++;
      end
      chk("tmo_cycles", 64'(nreq), 64'd8);
      chk("tmo_err", 64'(err_o), 64'd1);
      repeat (5) tick();
      chk("tmo_req", 64'(instr_req_o), 64'd0);
      chk("tmo_busy", 64'(busy_o), 64'd0);
      chk("tmo_sticky", 64'(err_o), 64'd1);
    end
`else
    chk("no_err", 64'(err_o), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
